// File: rtl/conv_sa_post_row_pv.sv
// conv_sa_post_row_pv: post-processing row for the conv systolic array.
// Each of P lanes picks one of NB block column-sums, keeps a running
// activation sum p, subtracts the zero-point correction wz*p and emits two
// results. Control flags ripple one lane per cycle to match the column skew.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_vld       item valid at lane 0 this cycle
//   in_rstp      restart p accumulation with this item
//   in_sel       block index to select (>= NB flags err)
//   sum1, sum2   column sums, lane j block b at [(b*P+j)*SW +: SW]
//   x            last-row activation, lane j at [j*XW +: XW]
//   wz           weight zero-point, lane j at [j*WZW +: WZW]
//   out_vld      per-lane result valid (one beat per item)
//   y1, y2       per-lane results, lane j at [j*SW +: SW]
//   err          sticky out-of-range select flag
module conv_sa_post_row_pv #(
   parameter  int P    = 16,
   parameter  int NB   = 4,
   parameter  int SW   = 32,
   parameter  int XW   = 8,
   parameter  int WZW  = 8,
   parameter  int SAT  = 0,
   localparam int SELW = (NB > 1) ? $clog2(NB) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_vld,
   input  logic                 in_rstp,
   input  logic [SELW-1:0]      in_sel,
   input  logic [NB*P*SW-1:0]   sum1,
   input  logic [NB*P*SW-1:0]   sum2,
   input  logic [P*XW-1:0]      x,
   input  logic [P*WZW-1:0]     wz,
   output logic [P-1:0]         out_vld,
   output logic [P*SW-1:0]      y1,
   output logic [P*SW-1:0]      y2,
   output logic                 err
);
   // lane flags: lane 0 sees the inputs directly, lane j the j-cycle delayed copy
   logic [P-1:0]    lv, lr;
   logic [SELW-1:0] ls [P];
   logic [P-2:0]    cv, cr;
   logic [SELW-1:0] cs [P-1];

   always_comb begin
      lv = {cv, in_vld};
      lr = {cr, in_rstp};
      ls[0] = in_sel;
      for (int i = 1; i < P; i++) ls[i] = cs[i-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cv <= '0;
         cr <= '0;
         for (int i = 0; i < P - 1; i++) cs[i] <= '0;
         err <= 1'b0;
      end else begin
         cv <= lv[P-2:0];
         cr <= lr[P-2:0];
         for (int i = 0; i < P - 1; i++) cs[i] <= ls[i];
         if (in_vld && int'(in_sel) >= NB) err <= 1'b1;
      end
   end

   // signed a-b; with SAT an overflow clamps towards the sign of a
   function automatic logic [SW-1:0] sub_sat(input logic [SW-1:0] a, input logic [SW-1:0] b);
      logic [SW-1:0] d;
      logic          ovf;
      d   = a - b;
      ovf = (a[SW-1] ^ b[SW-1]) & (d[SW-1] ^ a[SW-1]);
      return (SAT != 0 && ovf) ? {a[SW-1], {(SW-1){~a[SW-1]}}} : d;
   endfunction

   for (genvar j = 0; j < P; j++) begin : g_lane
      logic [SW-1:0] p, s1, s2, c, p_next, xv, ya, yb;
      logic          v1, ov, ok;
      int            sidx;
      assign xv     = SW'(x[j*XW +: XW]);
      assign ok     = int'(ls[j]) < NB;
      assign sidx   = ok ? int'(ls[j]) : 0;
      assign p_next = lr[j] ? xv : p + xv;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            p  <= '0;
            s1 <= '0;
            s2 <= '0;
            c  <= '0;
            v1 <= 1'b0;
            ov <= 1'b0;
            ya <= '0;
            yb <= '0;
         end else begin
            v1 <= lv[j];
            ov <= v1;
            if (lv[j]) begin
               p  <= p_next;
               s1 <= ok ? sum1[(sidx*P+j)*SW +: SW] : '0;
               s2 <= ok ? sum2[(sidx*P+j)*SW +: SW] : '0;
               c  <= SW'(wz[j*WZW +: WZW]) * p_next;
            end
            if (v1) begin
               ya <= sub_sat(s1, c);
               yb <= sub_sat(s2, c);
            end
         end
      end
      assign out_vld[j]        = ov;
      assign y1[j*SW +: SW]    = ya;
      assign y2[j*SW +: SW]    = yb;
   end
endmodule

// File: tb/tb_conv_sa_post_row_pv.sv
// tb_conv_sa_post_row_pv: checks a wrapping and a saturating instance of the
// post-processing row against a per-lane scoreboard built from phase tables.
module tb_conv_sa_post_row_pv;
   localparam int P  = 4;
   localparam int NB = 3;
   localparam int SW = 32;

   logic              clk = 1'b0, rst_n = 1'b0, in_vld = 1'b0, in_rstp = 1'b0;
   logic [1:0]        in_sel = '0;
   logic [NB*P*SW-1:0] sum1 = '0, sum2 = '0;
   logic [P*8-1:0]    x = '0, wz = '0;
   logic [P-1:0]      ov0, ov1;
   logic [P*SW-1:0]   a0, b0, a1, b1;
   logic              e0, e1;

   always #5 clk = ~clk;

   conv_sa_post_row_pv #(.P(P), .NB(NB), .SW(SW), .XW(8), .WZW(8), .SAT(0)) u0 (
      .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rstp(in_rstp), .in_sel(in_sel),
      .sum1(sum1), .sum2(sum2), .x(x), .wz(wz),
      .out_vld(ov0), .y1(a0), .y2(b0), .err(e0));

   conv_sa_post_row_pv #(.P(P), .NB(NB), .SW(SW), .XW(8), .WZW(8), .SAT(1)) u1 (
      .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rstp(in_rstp), .in_sel(in_sel),
      .sum1(sum1), .sum2(sum2), .x(x), .wz(wz),
      .out_vld(ov1), .y1(a1), .y2(b1), .err(e1));

   // one phase: data held constant, up to three items; lit0/lit1 are the
   // hand-derived lane-0 y1 values (wrap / saturate), item k at [32k +: 32]
   typedef struct {
      logic [31:0] s1b, s2b;
      logic [7:0]  xv, wzv;
      int          n;
      logic [2:0]  vld, rstp;
      logic [5:0]  sel;
      logic [95:0] lit0, lit1;
   } ph_t;

   typedef struct {
      int unsigned cyc;
      logic [31:0] a0, b0, a1, b1;
      bit          has_lit;
      logic [31:0] lit0, lit1;
   } exp_t;

   ph_t         ph [6];
   ph_t         cur;
   exp_t        q [P][$];
   logic [31:0] la0 [P], lb0 [P], la1 [P], lb1 [P];
   logic [31:0] pm;
   bit          errm;
   int unsigned cyc;
   int          total, bad;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] msub(input logic [31:0] a, input logic [31:0] b, input bit sat);
      longint d;
      d = longint'($signed(a)) - longint'($signed(b));
      if (sat && d > 64'sh7FFF_FFFF) d = 64'sh7FFF_FFFF;
      if (sat && d < -64'sh8000_0000) d = -64'sh8000_0000;
      return d[31:0];
   endfunction

   // lane j block b sums: block 2 of sum1 is s1b+j, other blocks offset by 1000 each
   function automatic logic [31:0] s1v(input int j, input int b);
      return cur.s1b + 32'(j) + 32'(b * 1000) - 32'd2000;
   endfunction

   function automatic logic [31:0] s2v(input int j, input int b);
      return cur.s2b - 32'(j) + 32'(b * 7);
   endfunction

   task automatic set_data(input ph_t f);
      cur = f;
      for (int j = 0; j < P; j++) begin
         x[j*8 +: 8]  = f.xv;
         wz[j*8 +: 8] = f.wzv;
         for (int b = 0; b < NB; b++) begin
            sum1[(b*P+j)*SW +: SW] = s1v(j, b);
            sum2[(b*P+j)*SW +: SW] = s2v(j, b);
         end
      end
   endtask

   task automatic check();
      for (int j = 0; j < P; j++) begin
         bit   ev;
         exp_t e;
         ev = q[j].size() > 0 && q[j][0].cyc == cyc;
         chk($sformatf("vld sat0 l%0d c%0d", j, cyc), 128'(ov0[j]), 128'(ev));
         chk($sformatf("vld sat1 l%0d c%0d", j, cyc), 128'(ov1[j]), 128'(ev));
         if (ev) begin
            e = q[j].pop_front();
            la0[j] = e.a0;
            lb0[j] = e.b0;
            la1[j] = e.a1;
            lb1[j] = e.b1;
            if (e.has_lit) begin
               chk($sformatf("lit y1 sat0 c%0d", cyc), 128'(a0[31:0]), 128'(e.lit0));
               chk($sformatf("lit y1 sat1 c%0d", cyc), 128'(a1[31:0]), 128'(e.lit1));
            end
         end
         chk($sformatf("y1 sat0 l%0d c%0d", j, cyc), 128'(a0[j*SW +: SW]), 128'(la0[j]));
         chk($sformatf("y2 sat0 l%0d c%0d", j, cyc), 128'(b0[j*SW +: SW]), 128'(lb0[j]));
         chk($sformatf("y1 sat1 l%0d c%0d", j, cyc), 128'(a1[j*SW +: SW]), 128'(la1[j]));
         chk($sformatf("y2 sat1 l%0d c%0d", j, cyc), 128'(b1[j*SW +: SW]), 128'(lb1[j]));
      end
      chk($sformatf("err sat0 c%0d", cyc), 128'(e0), 128'(errm));
      chk($sformatf("err sat1 c%0d", cyc), 128'(e1), 128'(errm));
   endtask

   // advance one clock, check outputs, then drive the next item and score it
   task automatic step(input bit v, input bit r, input logic [1:0] s,
                       input bit hl, input logic [31:0] l0, input logic [31:0] l1);
      logic [31:0] c, sa, sb;
      exp_t        e;
      @(posedge clk);
      #1;
      cyc++;
      check();
      in_vld  = v;
      in_rstp = r;
      in_sel  = s;
      if (v && rst_n) begin
         pm = r ? 32'(cur.xv) : pm + 32'(cur.xv);
         c  = 32'(cur.wzv) * pm;
         if (int'(s) >= NB) errm = 1'b1;
         for (int j = 0; j < P; j++) begin
            sa = int'(s) < NB ? s1v(j, int'(s)) : 32'd0;
            sb = int'(s) < NB ? s2v(j, int'(s)) : 32'd0;
            e.cyc     = cyc + 32'(j) + 2;
            e.a0      = msub(sa, c, 1'b0);
            e.b0      = msub(sb, c, 1'b0);
            e.a1      = msub(sa, c, 1'b1);
            e.b1      = msub(sb, c, 1'b1);
            e.has_lit = hl && j == 0;
            e.lit0    = l0;
            e.lit1    = l1;
            q[j].push_back(e);
         end
      end
   endtask

   task automatic run_phase(input ph_t f);
      set_data(f);
      for (int k = 0; k < f.n; k++)
         step(f.vld[k], f.rstp[k], f.sel[2*k +: 2], 1'b1, f.lit0[32*k +: 32], f.lit1[32*k +: 32]);
      repeat (P + 3) step(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic clear_model();
      for (int j = 0; j < P; j++) begin
         q[j].delete();
         la0[j] = '0;
         lb0[j] = '0;
         la1[j] = '0;
         lb1[j] = '0;
      end
      pm   = '0;
      errm = 1'b0;
   endtask

   initial begin
      ph[0] = '{32'd100, 32'd200, 8'd3, 8'd5, 1, 3'b001, 3'b001, 6'b000010,
                96'd85, 96'd85};
      ph[1] = '{32'd50, 32'd60, 8'd2, 8'd4, 3, 3'b111, 3'b001, 6'b101010,
                {32'd26, 32'd34, 32'd42}, {32'd26, 32'd34, 32'd42}};
      ph[2] = '{32'h8000_0005, 32'h7FFF_FFF0, 8'd2, 8'd5, 1, 3'b001, 3'b001, 6'b000010,
                96'h7FFF_FFFB, 96'h8000_0000};
      ph[3] = '{32'd1100, 32'd20, 8'd7, 8'd3, 2, 3'b011, 3'b001, 6'b000111,
                {32'd0, 32'd58, 32'hFFFF_FFEB}, {32'd0, 32'd58, 32'hFFFF_FFEB}};
      ph[4] = '{32'd3000, 32'd10, 8'd5, 8'd2, 3, 3'b101, 3'b011, 6'b000000,
                {32'd980, 32'd0, 32'd990}, {32'd980, 32'd0, 32'd990}};
      ph[5] = '{32'd500, 32'd0, 8'd9, 8'd1, 1, 3'b001, 3'b000, 6'b000010,
                96'd491, 96'd491};
      total = 0;
      bad   = 0;
      cyc   = 0;
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      chk("reset out_vld", 128'({ov1, ov0}), 128'd0);
      chk("reset y1 sat0", 128'(a0), 128'd0);
      chk("reset y2 sat1", 128'(b1), 128'd0);
      chk("reset err", 128'({e1, e0}), 128'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) run_phase(ph[k]);
      // reset while an item sits between lane 0 and lane 1
      set_data(ph[0]);
      step(1'b1, 1'b1, 2'd2, 1'b0, 32'd0, 32'd0);
      step(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst out_vld", 128'({ov1, ov0}), 128'd0);
      chk("midrst y1", 128'({a1, a0}), 128'd0);
      chk("midrst y2", 128'({b1, b0}), 128'd0);
      chk("midrst err", 128'({e1, e0}), 128'd0);
      clear_model();
      repeat (2) step(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
      rst_n = 1'b1;
      repeat (P + 3) step(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
      run_phase(ph[5]);
      for (int j = 0; j < P; j++)
         chk($sformatf("drain lane %0d", j), 128'(q[j].size()), 128'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
